wishbus_ram_slave: RTL and testbench
====================================

Name: wishbus_ram_slave

Overview:
- Single-port on-chip RAM that terminates a Wishbone-classic bus.
- Sits directly downstream of the 4-user bus arbiter and serves as the memory device it drives.
- Decodes one transfer at a time with programmable wait states.
- Supports byte-lane writes and registered read data, and flags out-of-range addresses with an error termination instead of ack.

Parameters:
- ADDR_W, 12, word-address width on the bus.
- DATA_W, 32, data width; must be a multiple of 8.
- DEPTH, 1024, number of implemented words; must be ≤ 2**ADDR_W.
- WAIT_STATES, 1, extra cycles inserted before termination; valid range 0..15.

Ports:
- clk_i  in  1  single clock.
- rst_ni  in  1  asynchronous, active-low reset.
- cyc_i  in  1  bus cycle valid.
- stb_i  in  1  transfer strobe.
- we_i  in  1  1 = write, 0 = read.
- sel_i  in  DATA_W/8  byte-lane enables, active high.
- adr_i  in  ADDR_W  word address.
- dat_i  in  DATA_W  write data.
- dat_o  out  DATA_W  read data, valid only while ack_o=1.
- ack_o  out  1  normal termination, one-cycle pulse.
- err_o  out  1  error termination, one-cycle pulse.
- busy_o  out  1  transfer in progress (state ≠ IDLE).

Behaviour:
- Reset: rst_ni=0 forces the following asynchronously:
  - state=IDLE;
  - ack_o=0, err_o=0, busy_o=0;
  - dat_o=0;
  - wait counter=0.
- RAM contents are not reset.
- Request: a request is accepted in IDLE on a rising edge with cyc_i & stb_i = 1.
  - adr_i, we_i, sel_i and dat_i are captured into internal registers on that edge.
  - Later changes on the bus inputs are ignored until termination.
- FSM states:
  - IDLE: on a request, go to WAIT if WAIT_STATES>0, else go to TERM. Load counter = WAIT_STATES-1.
  - WAIT: decrement the counter each cycle; go to TERM when counter==0 at the edge.
  - TERM: assert ack_o or err_o for exactly one cycle, then go to IDLE unconditionally. The next request is accepted no earlier than the cycle after TERM.
- Latency: termination is asserted WAIT_STATES+1 cycles after the accepting edge. With WAIT_STATES=0, ack is high in the cycle immediately after acceptance.
- Abort: if cyc_i falls in WAIT, go to IDLE next edge.
  - No ack or err is issued.
  - A captured write is discarded, so RAM is unchanged.
- Address check: captured adr ≥ DEPTH gives err_o instead of ack_o.
  - Writes do not touch RAM.
  - Read dat_o = 0.
- Write: performed on the edge entering TERM. Only lanes with sel bit 1 are updated; sel=0 on all lanes still acks and changes nothing.
- Read: RAM is read on the edge entering TERM. dat_o is registered and valid during the TERM cycle; it returns to 0 after TERM. Lanes with sel bit 0 read as 0.
- Mutual exclusion: ack_o and err_o are never high together. busy_o is 1 in WAIT and TERM.
- Back-to-back transfers: stb_i held high across a termination is not re-accepted in TERM. It is accepted in the following IDLE cycle, giving a minimum of WAIT_STATES+2 cycles per transfer.
- Reset mid-transfer: returns to IDLE immediately.
  - Any pending ack or err is dropped.
  - No write occurs unless the write edge has already passed.

Test Plan:
- Single word write, then read, with WAIT_STATES=1:
  - Stimulus: write adr=0x005, dat=0xDEADBEEF, sel=4'hF; then read 0x005.
  - Required: ack_o 2 cycles after each accept; dat_o=0xDEADBEEF during read ack.
- Byte-lane write:
  - Stimulus: preload 0x11223344 at 0x010; write dat=0xAABBCCDD with sel=4'b0101; read back.
  - Required: dat_o=0x11BB33DD.
- Out-of-range access with DEPTH=1024:
  - Stimulus: write to adr=0x400, then read adr=0x400.
  - Required: err_o pulses once per access, ack_o stays 0, read dat_o=0, and word 0x000 is unchanged.
- Abort:
  - Stimulus: WAIT_STATES=3, accept a write to 0x020 of 0x12345678, drop cyc_i 1 cycle after accept.
  - Required: no ack_o or err_o, busy_o=0 next cycle, and a read of 0x020 returns the old value.
- Reset mid-transfer:
  - Stimulus: deassert rst_ni asynchronously (mid-cycle) during WAIT.
  - Required: ack_o, err_o, busy_o and dat_o are 0 before the next clock edge; the FSM accepts a new request right after rst_ni returns high.
- Back-to-back reads with WAIT_STATES=0:
  - Stimulus: hold cyc_i & stb_i high with addresses 1, 2, 3.
  - Required: ack_o every 2nd cycle, returning the three preloaded words in order.

Source files
------------

// File: rtl/wishbus_ram_slave.sv
// Wishbone-classic single-port RAM slave with programmable wait states,
// byte-lane writes, registered read data and error termination for unmapped words.
module wishbus_ram_slave #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cyc_i,
    input  logic                stb_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] sel_i,
    input  logic [ADDR_W-1:0]   adr_i,
    input  logic [DATA_W-1:0]   dat_i,
    output logic [DATA_W-1:0]   dat_o,
    output logic                ack_o,
    output logic                err_o,
    output logic                busy_o
);
    localparam int LANES = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic NO_WAIT = (WAIT_STATES == 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_TERM = 2'd2;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] adr_q;
    logic              we_q;
    logic [LANES-1:0]  sel_q;
    logic [DATA_W-1:0] dat_q;

    logic              req;
    logic              go_term;
    logic              in_range;
    logic              eff_we;
    logic [ADDR_W-1:0] eff_adr;
    logic [LANES-1:0]  eff_sel;
    logic [DATA_W-1:0] eff_dat;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_masked;

    logic [DATA_W-1:0] mem [DEPTH];

    // With no wait states the access happens on the accepting edge itself,
    // so the live bus values stand in for the not-yet-captured registers.
    always_comb begin
        req = cyc_i & stb_i;
        if (state == S_IDLE) begin
            eff_adr = adr_i;
            eff_we  = we_i;
            eff_sel = sel_i;
            eff_dat = dat_i;
        end else begin
            eff_adr = adr_q;
            eff_we  = we_q;
            eff_sel = sel_q;
            eff_dat = dat_q;
        end
        go_term  = ((state == S_IDLE) && req && NO_WAIT) ||
                   ((state == S_WAIT) && cyc_i && (cnt == '0));
        in_range = ({1'b0, eff_adr} < DEPTH_LIM);
        idx      = eff_adr[IDX_W-1:0];
        rd_word  = mem[idx];
        rd_masked = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (eff_sel[i]) begin
                rd_masked[8*i +: 8] = rd_word[8*i +: 8];
            end
        end
    end

    assign busy_o = (state != S_IDLE);

    // RAM shares this block so no write can land while reset is held;
    // its contents are deliberately never cleared.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
            cnt   <= '0;
            adr_q <= '0;
            we_q  <= 1'b0;
            sel_q <= '0;
            dat_q <= '0;
            ack_o <= 1'b0;
            err_o <= 1'b0;
            dat_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        adr_q <= adr_i;
                        we_q  <= we_i;
                        sel_q <= sel_i;
                        dat_q <= dat_i;
                        cnt   <= CNT_INIT;
                        state <= NO_WAIT ? S_TERM : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!cyc_i) begin
                        state <= S_IDLE;
                    end else if (cnt == '0) begin
                        state <= S_TERM;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_TERM: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            ack_o <= go_term & in_range;
            err_o <= go_term & ~in_range;
            dat_o <= (go_term && in_range && !eff_we) ? rd_masked : '0;

            if (go_term && in_range && eff_we) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    if (eff_sel[i]) begin
                        mem[idx][8*i +: 8] <= eff_dat[8*i +: 8];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_wishbus_ram_slave.sv
// Self-checking bench: three slaves (WAIT_STATES 1, 3, 0) against a word-array
// reference model, with directed vectors, corner sequences and random traffic.
module tb_wishbus_ram_slave;
    localparam int N     = 3;
    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst_n [N];
    logic          cyc   [N];
    logic          stb   [N];
    logic          we    [N];
    logic [3:0]    sel   [N];
    logic [AW-1:0] adr   [N];
    logic [DW-1:0] dat_w [N];
    logic [DW-1:0] dat_r [N];
    logic          ack   [N];
    logic          err   [N];
    logic          busy  [N];

    int checks   = 0;
    int failures = 0;
    logic [31:0] model [N][DEPTH];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        wishbus_ram_slave #(
            .ADDR_W(AW),
            .DATA_W(DW),
            .DEPTH(DEPTH),
            .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 3 : 0))
        ) dut (
            .clk_i(clk),
            .rst_ni(rst_n[g]),
            .cyc_i(cyc[g]),
            .stb_i(stb[g]),
            .we_i(we[g]),
            .sel_i(sel[g]),
            .adr_i(adr[g]),
            .dat_i(dat_w[g]),
            .dat_o(dat_r[g]),
            .ack_o(ack[g]),
            .err_o(err[g]),
            .busy_o(busy[g])
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = s[b] ? 8'hFF : 8'h00;
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_write(input int k, input logic [11:0] a, input logic [3:0] s,
                               input logic [31:0] d);
        logic [31:0] m;
        m = lane_mask(s);
        if (a < DEPTH) model[k][a[9:0]] = (model[k][a[9:0]] & ~m) | (d & m);
    endtask

    // One complete transfer; checks generic timing rules, returns the termination seen.
    task automatic xfer(input int k, input logic w, input logic [11:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic got_ack, output logic got_err,
                        output logic [31:0] got_dat);
        int lat;
        bit seen;
        @(negedge clk);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; sel[k] = s; dat_w[k] = d;
        @(posedge clk);
        #1;
        stb[k] = 1'b0; we[k] = ~w; adr[k] = a ^ 12'h5A5; sel[k] = ~s; dat_w[k] = $urandom;
        got_ack = 1'b0; got_err = 1'b0; got_dat = '0; seen = 1'b0; lat = 0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            if (n == 1) check("busy_during", 32'(busy[k]), 32'd1);
            if (ack[k] || err[k]) begin
                seen = 1'b1; lat = n;
                got_ack = ack[k]; got_err = err[k]; got_dat = dat_r[k];
            end
        end
        cyc[k] = 1'b0;
        check("term_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("latency", 32'(lat), 32'(ws_of(k) + 1));
            @(negedge clk);
            check("pulse_end", 32'({ack[k], err[k], busy[k]}), 32'd0);
            check("dat_clear", dat_r[k], 32'd0);
        end
    endtask

    task automatic model_xfer(input int k, input logic w, input logic [11:0] a,
                              input logic [3:0] s, input logic [31:0] d, input string name);
        logic ga, ge;
        logic [31:0] gd;
        bit inr;
        inr = (a < DEPTH);
        xfer(k, w, a, s, d, ga, ge, gd);
        check({name, "_ack"}, 32'(ga), 32'(inr));
        check({name, "_err"}, 32'(ge), 32'(!inr));
        if (!w) check({name, "_dat"}, gd, inr ? (model[k][a[9:0]] & lane_mask(s)) : 32'd0);
        if (w) model_write(k, a, s, d);
    endtask

    typedef struct {
        logic        w;
        logic [11:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic        eack;
        logic        eerr;
        logic [31:0] edat;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        logic ga, ge;
        logic [31:0] gd;
        logic [11:0] ra;
        bit saw;

        vecs.push_back('{1'b1, 12'h005, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 12'h005, 4'hF, 32'h0,       1'b1, 1'b0, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 12'h010, 4'hF, 32'h11223344, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 12'h010, 4'h5, 32'hAABBCCDD, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 12'h010, 4'hF, 32'h0,       1'b1, 1'b0, 32'h11BB33DD});
        vecs.push_back('{1'b1, 12'h000, 4'hF, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 12'h400, 4'hF, 32'h0BADBAD0, 1'b0, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 12'h400, 4'hF, 32'h0,       1'b0, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 12'h000, 4'hF, 32'h0,       1'b1, 1'b0, 32'hCAFEF00D});
        vecs.push_back('{1'b1, 12'h005, 4'h0, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 12'h005, 4'h3, 32'h0,       1'b1, 1'b0, 32'h0000BEEF});
        vecs.push_back('{1'b0, 12'hFFF, 4'hF, 32'h0,       1'b0, 1'b1, 32'h0});

        for (int k = 0; k < N; k++) begin
            rst_n[k] = 1'b0; cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
            sel[k] = '0; adr[k] = '0; dat_w[k] = '0;
        end
        #12;
        for (int k = 0; k < N; k++) begin
            check("reset_ack", 32'(ack[k]), 32'd0);
            check("reset_err", 32'(err[k]), 32'd0);
            check("reset_busy", 32'(busy[k]), 32'd0);
            check("reset_dat", dat_r[k], 32'd0);
        end
        @(negedge clk);
        for (int k = 0; k < N; k++) rst_n[k] = 1'b1;

        // Directed vectors on the WAIT_STATES=1 slave.
        foreach (vecs[i]) begin
            xfer(0, vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d, ga, ge, gd);
            check($sformatf("vec%0d_ack", i), 32'(ga), 32'(vecs[i].eack));
            check($sformatf("vec%0d_err", i), 32'(ge), 32'(vecs[i].eerr));
            if (!vecs[i].w) check($sformatf("vec%0d_dat", i), gd, vecs[i].edat);
            if (vecs[i].w) model_write(0, vecs[i].a, vecs[i].s, vecs[i].d);
        end

        for (int k = 0; k < N; k++) begin
            for (int a = 0; a < 16; a++) model_xfer(k, 1'b1, 12'(a), 4'hF, $urandom, "preload");
            for (int a = 1020; a < 1024; a++) model_xfer(k, 1'b1, 12'(a), 4'hF, $urandom, "preload");
        end

        // Abort on the WAIT_STATES=3 slave: cyc drops one cycle after accept.
        model_xfer(1, 1'b1, 12'h020, 4'hF, 32'h0BADC0DE, "abort_pre");
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 12'h020; sel[1] = 4'hF;
        dat_w[1] = 32'h12345678;
        @(posedge clk);
        #1 stb[1] = 1'b0;
        @(negedge clk);
        check("abort_busy_wait", 32'(busy[1]), 32'd1);
        cyc[1] = 1'b0;
        @(negedge clk);
        check("abort_busy_idle", 32'(busy[1]), 32'd0);
        saw = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (ack[1] || err[1]) saw = 1'b1;
        end
        check("abort_no_term", 32'(saw), 32'd0);
        model_xfer(1, 1'b0, 12'h020, 4'hF, 32'h0, "abort_read");

        // Asynchronous reset while in WAIT.
        model_xfer(1, 1'b1, 12'h021, 4'hF, 32'h600DF00D, "rst_pre");
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 12'h021; sel[1] = 4'hF;
        dat_w[1] = 32'hFFFF0000;
        @(posedge clk);
        #1 stb[1] = 1'b0;
        @(posedge clk);
        #2 rst_n[1] = 1'b0;
        #1;
        check("rst_mid_ack", 32'(ack[1]), 32'd0);
        check("rst_mid_err", 32'(err[1]), 32'd0);
        check("rst_mid_busy", 32'(busy[1]), 32'd0);
        check("rst_mid_dat", dat_r[1], 32'd0);
        #1 rst_n[1] = 1'b1;
        cyc[1] = 1'b0;
        model_xfer(1, 1'b0, 12'h021, 4'hF, 32'h0, "rst_after");

        // Back-to-back reads with stb held high on the WAIT_STATES=0 slave.
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; sel[2] = 4'hF; adr[2] = 12'd1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n % 2 == 1) begin
                check($sformatf("b2b_ack%0d", n), 32'(ack[2]), 32'd1);
                check($sformatf("b2b_dat%0d", n), dat_r[2], model[2][(n + 1) / 2]);
                if (n < 5) adr[2] = 12'((n + 1) / 2 + 1);
                else begin cyc[2] = 1'b0; stb[2] = 1'b0; end
            end else begin
                check($sformatf("b2b_gap%0d", n), 32'(ack[2]), 32'd0);
            end
        end

        // Random traffic on all slaves.
        for (int k = 0; k < N; k++) begin
            for (int t = 0; t < 30; t++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: ra = 12'($urandom_range(0, 15));
                    6, 7:             ra = 12'(1020 + $urandom_range(0, 3));
                    8:                ra = 12'(1024 + $urandom_range(0, 7));
                    default:          ra = 12'hFFF;
                endcase
                model_xfer(k, 1'($urandom_range(0, 1)), ra, 4'($urandom_range(0, 15)),
                           $urandom, "rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
